// File: rtl/icache_pkg.sv
// Shared types and geometry defaults for the direct-mapped instruction cache.
package icache_pkg;
  typedef enum logic {IDLE, REFILL} state_t;

  localparam int DEF_LINES = 16;
  localparam int DEF_WORDS = 4;
  localparam int DEF_OB    = $clog2(DEF_WORDS);
  localparam int DEF_IB    = $clog2(DEF_LINES);
  localparam int DEF_TW    = 32 - DEF_OB - DEF_IB - 2;
endpackage

// File: rtl/icache_ctrl_if.sv
// Fetch-side lookup port plus refill port; ICACHE_STATS_EN adds hit/miss counters.
interface icache_ctrl_if;
  logic        En;
  logic [31:0] Addr;
  logic [31:0] Data;
  logic        Imiss;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemRdy;
  logic [31:0] MemData;
`ifdef ICACHE_STATS_EN
  logic [31:0] HitCount;
  logic [31:0] MissCount;

  modport master (output En, Addr, MemRdy, MemData,
                  input  Data, Imiss, MemReq, MemAddr, HitCount, MissCount);
  modport slave  (input  En, Addr, MemRdy, MemData,
                  output Data, Imiss, MemReq, MemAddr, HitCount, MissCount);
`else
  modport master (output En, Addr, MemRdy, MemData,
                  input  Data, Imiss, MemReq, MemAddr);
  modport slave  (input  En, Addr, MemRdy, MemData,
                  output Data, Imiss, MemReq, MemAddr);
`endif
endinterface

// File: rtl/icache_data_ram.sv
// Line data storage: synchronous write, asynchronous read, indexed by {line, word}.
module icache_data_ram
  import icache_pkg::*;
#(
  parameter  int LINES = DEF_LINES,
  parameter  int WORDS = DEF_WORDS,
  localparam int OB    = $clog2(WORDS),
  localparam int IB    = $clog2(LINES)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [IB-1:0] widx_i,
  input  logic [OB-1:0] woff_i,
  input  logic [31:0]   wdata_i,
  input  logic [IB-1:0] ridx_i,
  input  logic [OB-1:0] roff_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [LINES*WORDS];

  always_ff @(posedge clk)
    if (we_i) mem_q[{widx_i, woff_i}] <= wdata_i;

  assign rdata_o = mem_q[{ridx_i, roff_i}];
endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped I-cache controller: 1-cycle hits, whole-line refill on miss.
// Optional ICACHE_STATS_EN adds saturating hit/miss counters.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS
) (
  input logic         Clk,
  input logic         Rst,
  icache_ctrl_if.slave bus
);
  localparam int OB = $clog2(WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TW = 32 - OB - IB - 2;

  logic [OB-1:0] off;
  logic [IB-1:0] idx;
  logic [TW-1:0] tag;
  logic          hit, beat, last, unused_addr;
  logic [31:0]   rd_word;

  state_t        state_q;
  logic [LINES-1:0] valid_q;
  logic [TW-1:0] tag_q [LINES];
  logic [IB-1:0] m_idx_q;
  logic [TW-1:0] m_tag_q;
  logic [OB-1:0] m_off_q, cnt_q;
  logic [31:0]   hold_q, data_q, maddr_q;
  logic          imiss_q, mreq_q;

  assign off         = bus.Addr[OB+1:2];
  assign idx         = bus.Addr[OB+IB+1:OB+2];
  assign tag         = bus.Addr[31:OB+IB+2];
  assign unused_addr = ^bus.Addr[1:0];

  assign hit  = valid_q[idx] && (tag_q[idx] == tag);
  assign beat = (state_q == REFILL) && bus.MemRdy;
  assign last = beat && (&cnt_q);

  icache_data_ram #(.LINES(LINES), .WORDS(WORDS)) u_ram (
    .clk    (Clk),
    .we_i   (beat),
    .widx_i (m_idx_q),
    .woff_i (cnt_q),
    .wdata_i(bus.MemData),
    .ridx_i (idx),
    .roff_i (off),
    .rdata_o(rd_word)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      for (int i = 0; i < LINES; i++) tag_q[i] <= '0;
      m_idx_q <= '0;
      m_tag_q <= '0;
      m_off_q <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      data_q  <= '0;
      maddr_q <= '0;
      imiss_q <= 1'b0;
      mreq_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.En) begin
          if (hit) begin
            data_q <= rd_word;
          end else begin
            imiss_q <= 1'b1;
            mreq_q  <= 1'b1;
            maddr_q <= {bus.Addr[31:OB+2], {(OB+2){1'b0}}};
            m_idx_q <= idx;
            m_tag_q <= tag;
            m_off_q <= off;
            cnt_q   <= '0;
            state_q <= REFILL;
          end
        end
        REFILL: if (bus.MemRdy) begin
          if (cnt_q == m_off_q) hold_q <= bus.MemData;
          cnt_q <= cnt_q + 1'b1;
          // Line becomes visible only once every word has landed.
          if (last) begin
            valid_q[m_idx_q] <= 1'b1;
            tag_q[m_idx_q]   <= m_tag_q;
            data_q  <= (&m_off_q) ? bus.MemData : hold_q;
            imiss_q <= 1'b0;
            mreq_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            maddr_q <= maddr_q + 32'd4;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Data    = data_q;
  assign bus.Imiss   = imiss_q;
  assign bus.MemReq  = mreq_q;
  assign bus.MemAddr = maddr_q;

`ifdef ICACHE_STATS_EN
  logic        lookup;
  logic [31:0] hits_q, misses_q;

  assign lookup = (state_q == IDLE) && bus.En;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else if (lookup) begin
      if (hit && hits_q != '1)    hits_q   <= hits_q + 32'd1;
      if (!hit && misses_q != '1) misses_q <= misses_q + 32'd1;
    end
  end

  assign bus.HitCount  = hits_q;
  assign bus.MissCount = misses_q;
`endif
endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl: directed scenarios plus random lookups against a tag model.
module tb_icache_ctrl;
  logic Clk = 1'b0;
  logic Rst;

  icache_ctrl_if bus();
  icache_ctrl #(.LINES(16), .WORDS(4)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

  always #5 Clk = ~Clk;

  typedef struct { logic [31:0] data; bit hit; } exp_t;

  int   tests = 0, fails = 0;
  exp_t sbq[$];
  bit   pat[$];
  bit   mon_en = 0;
  int   rdy_mode = 1;
  bit          m_valid [16];
  logic [23:0] m_tag   [16];
  int   hit_m = 0, miss_m = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a < 32'h10) return 32'h11 * ({30'd0, a[3:2]} + 32'd1);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge Clk); #1;
  endtask

  task automatic wait_refill;
    int n = 0;
    while (bus.Imiss && n < 200) begin tick; n++; end
    chk("refill_timeout", {31'd0, bus.Imiss}, 32'd0);
  endtask

  // Present one lookup; the model decides hit/miss and the expected word.
  task automatic issue(input logic [31:0] a);
    logic [3:0]  ix = a[7:4];
    logic [23:0] tg = a[31:8];
    bit h;
    h = m_valid[ix] && (m_tag[ix] == tg);
    sbq.push_back('{memf({a[31:2], 2'b00}), h});
    if (h) hit_m++;
    else begin miss_m++; m_valid[ix] = 1; m_tag[ix] = tg; end
    bus.En = 1'b1; bus.Addr = a;
    tick;
    bus.En = 1'b0;
    if (bus.Imiss) wait_refill;
    repeat ($urandom_range(0, 2)) tick;
  endtask

  // Backing memory: answers from memf at the beat address.
  initial begin
    bus.MemRdy = 1'b0; bus.MemData = '0;
    forever begin
      @(posedge Clk); #1;
      if (pat.size() > 0 && bus.MemReq) bus.MemRdy = pat.pop_front();
      else if (rdy_mode == 1)           bus.MemRdy = 1'b1;
      else                              bus.MemRdy = ($urandom_range(0, 9) < 7);
      bus.MemData = bus.MemRdy ? memf(bus.MemAddr) : $urandom;
    end
  end

  // Scoreboard monitor: a lookup edge either hits (data now) or opens a refill.
  initial begin
    bit l_en = 0, l_im = 0, pend = 0;
    exp_t pe, e;
    forever begin
      @(negedge Clk);
      if (!mon_en) begin
        l_en = 0; pend = 0;
      end else begin
        if (pend) begin
          if (!bus.Imiss) begin chk("miss_data", bus.Data, pe.data); pend = 0; end
        end else if (l_en && !l_im) begin
          if (sbq.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_lookup: got lookup expected none at %0t", $time);
          end else begin
            e = sbq.pop_front();
            chk("hit_flag", {31'd0, !bus.Imiss}, {31'd0, e.hit});
            if (!bus.Imiss) chk("hit_data", bus.Data, e.data);
            else begin pend = 1; pe = e; end
          end
        end
        l_en = bus.En; l_im = bus.Imiss;
      end
    end
  end

  // Refill port rules: stall holds address/request, every refill takes 4 beats.
  initial begin
    bit p_req = 0, p_rdy = 0, p_im = 0;
    logic [31:0] p_addr = '0;
    int beats = 0;
    forever begin
      @(negedge Clk);
      if (Rst) begin
        beats = 0; p_req = 0; p_rdy = 0; p_im = 0;
      end else begin
        if (p_req && !p_rdy) begin
          chk("memaddr_hold", bus.MemAddr, p_addr);
          chk("memreq_hold", {31'd0, bus.MemReq}, 32'd1);
        end
        if (p_req && p_rdy) beats++;
        if (p_im && !bus.Imiss) begin chk("beat_count", beats, 32'd4); beats = 0; end
        p_req = bus.MemReq; p_rdy = bus.MemRdy; p_addr = bus.MemAddr; p_im = bus.Imiss;
      end
    end
  end

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    logic [31:0] a;
    Rst = 1'b1; bus.En = 1'b0; bus.Addr = '0;
    repeat (2) tick;
    chk("rst_data",    bus.Data,    32'd0);
    chk("rst_imiss",   {31'd0, bus.Imiss},  32'd0);
    chk("rst_memreq",  {31'd0, bus.MemReq}, 32'd0);
    chk("rst_memaddr", bus.MemAddr, 32'd0);
    Rst = 1'b0;
    tick;

    // Cold miss at address 0, memory always ready.
    bus.En = 1'b1; bus.Addr = 32'h0;
    tick;
    chk("cold_imiss",  {31'd0, bus.Imiss},  32'd1);
    chk("cold_memreq", {31'd0, bus.MemReq}, 32'd1);
    chk("cold_addr0",  bus.MemAddr, 32'h0);
    bus.En = 1'b0;
    for (int k = 1; k < 4; k++) begin
      tick;
      chk("cold_addr_step", bus.MemAddr, 32'(4 * k));
    end
    tick;
    chk("cold_data",   bus.Data, 32'h11);
    chk("cold_imiss0", {31'd0, bus.Imiss},  32'd0);
    chk("cold_req0",   {31'd0, bus.MemReq}, 32'd0);

    bus.En = 1'b1; bus.Addr = 32'h8;
    tick;
    chk("hit_data8",  bus.Data, 32'h33);
    chk("hit_imiss",  {31'd0, bus.Imiss},  32'd0);
    chk("hit_memreq", {31'd0, bus.MemReq}, 32'd0);
    bus.En = 1'b0;
    m_valid[0] = 1; m_tag[0] = '0; hit_m = 1; miss_m = 1;
`ifdef ICACHE_STATS_EN
    chk("stats_miss1", bus.MissCount, 32'd1);
    chk("stats_hit1",  bus.HitCount,  32'd1);
`endif

    mon_en = 1;
    tick;
    issue(32'h100);
    issue(32'h0);
    issue(32'h4);
    // Stalled memory, requested word at offset 2.
    pat = '{1, 0, 0, 1, 1, 0, 1};
    issue(32'h208);

    rdy_mode = 0;
    repeat (300) begin
      case ($urandom_range(0, 3))
        0: a[31:8] = 24'h0;
        1: a[31:8] = 24'h1;
        2: a[31:8] = 24'h2;
        default: a[31:8] = 24'hFFFFFF;
      endcase
      a[7:4] = 4'($urandom_range(0, 7));
      a[3:0] = 4'($urandom);
      issue(a);
    end
    repeat (3) tick;
    chk("sb_drain", sbq.size(), 32'd0);
`ifdef ICACHE_STATS_EN
    chk("stats_miss_rand", bus.MissCount, miss_m);
    chk("stats_hit_rand",  bus.HitCount,  hit_m);
`endif
    mon_en = 0;

    // Reset after two accepted beats of a refill.
    rdy_mode = 1;
    bus.En = 1'b1; bus.Addr = 32'h0;
    tick;
    bus.En = 1'b0;
    tick; tick;
    #2 Rst = 1'b1;
    #1;
    chk("mid_rst_memreq",  {31'd0, bus.MemReq}, 32'd0);
    chk("mid_rst_imiss",   {31'd0, bus.Imiss},  32'd0);
    chk("mid_rst_data",    bus.Data,    32'd0);
    chk("mid_rst_memaddr", bus.MemAddr, 32'd0);
    tick; tick;
    Rst = 1'b0;
    tick;
    bus.En = 1'b1; bus.Addr = 32'h0;
    tick;
    chk("post_rst_miss", {31'd0, bus.Imiss}, 32'd1);
    bus.En = 1'b0;
    wait_refill;
    chk("post_rst_data", bus.Data, 32'h11);
`ifdef ICACHE_STATS_EN
    chk("stats_miss_rst", bus.MissCount, 32'd1);
    chk("stats_hit_rst",  bus.HitCount,  32'd0);
`endif
    repeat (2) tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
